// File: rtl/ik_job_sequencer.sv
// ik_job_sequencer: upstream job sequencer for the inverse-kinematics core.
// Latency: in-range job -> result after SETTLE_CYCLES edges; out-of-range job -> 1 edge.
// Backpressure: out_ready low holds the result stable and in_ready low; no input bubble on handshake.
//
// Ports:
//   clock, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_x/in_y request handshake, sign-magnitude Q16.15 target
//   ik_x/ik_y                   target held stable towards the IK core
//   ik_theta1/ik_theta2         angles from the IK core (no handshake)
//   out_valid/out_ready         result handshake
//   out_theta1/out_theta2       captured angles (0 when rejected)
//   out_err                     request rejected as out of reach
//   busy                        high while waiting for the IK pipeline to settle
//   job_count                   completed result handshakes, wraps at 2^16
module ik_job_sequencer #(
  parameter int                    BIT_WIDTH     = 32,
  parameter int                    FRACTIONS     = 15,
  parameter int                    SETTLE_CYCLES = 100,
  parameter logic [BIT_WIDTH-1:0]  MAX_MAG       = 32'h000B8000
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_x,
  input  logic [BIT_WIDTH-1:0] in_y,
  output logic [BIT_WIDTH-1:0] ik_x,
  output logic [BIT_WIDTH-1:0] ik_y,
  input  logic [BIT_WIDTH-1:0] ik_theta1,
  input  logic [BIT_WIDTH-1:0] ik_theta2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_theta1,
  output logic [BIT_WIDTH-1:0] out_theta2,
  output logic                 out_err,
  output logic                 busy,
  output logic [15:0]          job_count
);

  // Elaboration-time sanity checks on the parameter set.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
    $error("ik_job_sequencer: SETTLE_CYCLES must be in 1..65535");
  end
  if (FRACTIONS < 0 || FRACTIONS > BIT_WIDTH - 2) begin : g_bad_frac
    $error("ik_job_sequencer: FRACTIONS must fit in the magnitude field");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  // The counter is loaded with N-1 so the edge that sees zero is the Nth edge
  // after the accept edge, which is the capture edge.
  localparam logic [15:0] CNT_LOAD = 16'(SETTLE_CYCLES - 1);

  // Only the magnitude field takes part in the reach check, so -0 behaves as 0.
  localparam logic [BIT_WIDTH-2:0] MAG_LIMIT = MAX_MAG[BIT_WIDTH-2:0];

  logic [1:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] ik_x_q, ik_x_d;
  logic [BIT_WIDTH-1:0] ik_y_q, ik_y_d;
  logic [BIT_WIDTH-1:0] theta1_q, theta1_d;
  logic [BIT_WIDTH-1:0] theta2_q, theta2_d;
  logic                 err_q, err_d;
  logic [15:0]          job_count_q, job_count_d;

  logic accept;
  logic in_range;
  logic out_hs;

  // in_ready is combinational so a result handshake can take a new request on
  // the same edge; it is gated by rst so nothing is offered during reset.
  assign in_ready = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
  assign accept   = in_valid & in_ready;
  assign out_hs   = (state_q == ST_OUT) & out_ready;
  assign in_range = (in_x[BIT_WIDTH-2:0] <= MAG_LIMIT) & (in_y[BIT_WIDTH-2:0] <= MAG_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ik_x_d      = ik_x_q;
    ik_y_d      = ik_y_q;
    theta1_d    = theta1_q;
    theta2_d    = theta2_q;
    err_d       = err_q;
    job_count_d = job_count_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          theta1_d = ik_theta1;
          theta2_d = ik_theta2;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        // Result is frozen until the consumer takes it.
        if (out_hs) begin
          job_count_d = job_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request overrides the IDLE fall-back above, giving zero-bubble
    // back-to-back operation on the result handshake edge.
    if (accept) begin
      if (in_range) begin
        ik_x_d  = in_x;
        ik_y_d  = in_y;
        cnt_d   = CNT_LOAD;
        err_d   = 1'b0;
        state_d = ST_SETTLE;
      end else begin
        // Rejected jobs never touch the IK core inputs.
        theta1_d = '0;
        theta2_d = '0;
        err_d    = 1'b1;
        state_d  = ST_OUT;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ik_x_q      <= '0;
      ik_y_q      <= '0;
      theta1_q    <= '0;
      theta2_q    <= '0;
      err_q       <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ik_x_q      <= ik_x_d;
      ik_y_q      <= ik_y_d;
      theta1_q    <= theta1_d;
      theta2_q    <= theta2_d;
      err_q       <= err_d;
      job_count_q <= job_count_d;
    end
  end

  assign ik_x       = ik_x_q;
  assign ik_y       = ik_y_q;
  assign out_theta1 = theta1_q;
  assign out_theta2 = theta2_q;
  assign out_err    = err_q;
  assign out_valid  = (state_q == ST_OUT);
  assign busy       = (state_q == ST_SETTLE);
  assign job_count  = job_count_q;

endmodule

// File: tb/tb_ik_job_sequencer.sv
// Directed self-checking bench for ik_job_sequencer (SETTLE_CYCLES = 100).
module tb_ik_job_sequencer;

  logic        clock = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y;
  logic [31:0] ik_x, ik_y;
  logic [31:0] ik_theta1, ik_theta2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_theta1, out_theta2;
  logic        out_err;
  logic        busy;
  logic [15:0] job_count;

  int tests_run    = 0;
  int tests_failed = 0;

  ik_job_sequencer #(
    .BIT_WIDTH(32), .FRACTIONS(15), .SETTLE_CYCLES(100), .MAX_MAG(32'h000B8000)
  ) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .ik_x(ik_x), .ik_y(ik_y), .ik_theta1(ik_theta1), .ik_theta2(ik_theta2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_theta1(out_theta1), .out_theta2(out_theta2), .out_err(out_err),
    .busy(busy), .job_count(job_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Advances until out_valid is seen (at most 300 edges); n = edges taken,
  // b = cycles busy was observed high along the way.
  task automatic wait_valid(output int n, output int b);
    n = 0;
    b = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      if (busy === 1'b1) b++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; ik_theta1 = '0; ik_theta2 = '0;
    #2;
    tests_run++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/vld/busy/err=%b expected 0000", {in_ready, out_valid, busy, out_err});
    end
    tests_run++;
    if ({ik_x, ik_y, out_theta1, out_theta2, job_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got ik_x=%h ik_y=%h th1=%h th2=%h jc=%h expected all 0", ik_x, ik_y, out_theta1, out_theta2, job_count);
    end
    @(posedge clock); #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_rdy: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    int n, b;
    in_x = 32'h00050000; in_y = 32'h00028000; in_valid = 1'b1;
    ik_theta1 = 32'h00012345; ik_theta2 = 32'h00006789;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (ik_x !== 32'h00050000 || ik_y !== 32'h00028000 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_accept: got ik_x=%h ik_y=%h busy=%b expected 00050000 00028000 1", ik_x, ik_y, busy);
    end
    wait_valid(n, b);
    tests_run++;
    if (n != 100 || b != 100) begin
      tests_failed++;
      $display("FAIL basic_latency: got edges=%0d busy_cycles=%0d expected 100 100", n, b);
    end
    ik_theta1 = 32'h7FFFFFFF; ik_theta2 = 32'h80000001;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_theta1 !== 32'h00012345 || out_theta2 !== 32'h00006789 || out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: got vld=%b th1=%h th2=%h err=%b expected 1 00012345 00006789 0", out_valid, out_theta1, out_theta2, out_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (job_count !== 16'd1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_handshake: got jc=%0d vld=%b expected 1 0", job_count, out_valid);
    end
  endtask

  task automatic test_reject;
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    xs[0] = 32'h000C0000; ys[0] = 32'h00000000;
    xs[1] = 32'h800C0000; ys[1] = 32'h00000000;
    xs[2] = 32'h00000000; ys[2] = 32'h000B8001;
    ik_theta1 = 32'h00001111; ik_theta2 = 32'h00002222;
    for (int i = 0; i < 3; i++) begin
      in_x = xs[i]; in_y = ys[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || out_err !== 1'b1 || out_theta1 !== 32'h0 || out_theta2 !== 32'h0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reject_%0d: got vld=%b err=%b th1=%h th2=%h busy=%b expected 1 1 0 0 0", i, out_valid, out_err, out_theta1, out_theta2, busy);
      end
      tests_run++;
      if (ik_x !== 32'h00050000 || ik_y !== 32'h00028000) begin
        tests_failed++;
        $display("FAIL reject_ik_hold_%0d: got ik_x=%h ik_y=%h expected 00050000 00028000", i, ik_x, ik_y);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if (job_count !== 16'(2 + i) || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reject_hs_%0d: got jc=%0d vld=%b expected %0d 0", i, job_count, out_valid, 2 + i);
      end
    end
  endtask

  task automatic test_boundary_backpressure;
    int n, b;
    logic stable;
    in_x = 32'h800B8000; in_y = 32'h00000000; in_valid = 1'b1;
    ik_theta1 = 32'h0000AAAA; ik_theta2 = 32'h80005555;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || out_err !== 1'b0 || ik_x !== 32'h800B8000 || ik_y !== 32'h0) begin
      tests_failed++;
      $display("FAIL boundary_accept: got busy=%b err=%b ik_x=%h ik_y=%h expected 1 0 800B8000 0", busy, out_err, ik_x, ik_y);
    end
    wait_valid(n, b);
    tests_run++;
    if (n != 100) begin
      tests_failed++;
      $display("FAIL boundary_latency: got %0d edges expected 100", n);
    end
    stable = 1'b1;
    in_x = 32'h00010000;
    for (int i = 0; i < 20; i++) begin
      ik_theta1 = $urandom; ik_theta2 = $urandom;
      in_valid = (i % 2 == 0);
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b0 || out_theta1 !== 32'h0000AAAA ||
          out_theta2 !== 32'h80005555 || ik_x !== 32'h800B8000 || busy !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    tests_run++;
    if (stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_hold: got rdy=%b vld=%b th1=%h th2=%h ik_x=%h expected 0 1 0000AAAA 80005555 800B8000", in_ready, out_valid, out_theta1, out_theta2, ik_x);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tests_run++;
    if (job_count !== 16'd5 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: got jc=%0d vld=%b expected 5 0", job_count, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int n, b;
    in_x = 32'h00010000; in_y = 32'h00020000; in_valid = 1'b1;
    ik_theta1 = 32'h11111111; ik_theta2 = 32'h22222222;
    tick();
    in_valid = 1'b0;
    wait_valid(n, b);
    tests_run++;
    if (out_theta1 !== 32'h11111111 || out_theta2 !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL b2b_first: got th1=%h th2=%h expected 11111111 22222222", out_theta1, out_theta2);
    end
    in_x = 32'h00030000; in_y = 32'h00040000; in_valid = 1'b1; out_ready = 1'b1;
    ik_theta1 = 32'h33333333; ik_theta2 = 32'h44444444;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || job_count !== 16'd6 || ik_x !== 32'h00030000 || ik_y !== 32'h00040000) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy=%b vld=%b jc=%0d ik_x=%h ik_y=%h expected 1 0 6 00030000 00040000", busy, out_valid, job_count, ik_x, ik_y);
    end
    // Count the cycles out_valid stays low starting from the accept edge.
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      n++;
      tick();
    end
    tests_run++;
    if (n != 100 || out_theta1 !== 32'h33333333 || out_theta2 !== 32'h44444444) begin
      tests_failed++;
      $display("FAIL b2b_second: got low_cycles=%0d th1=%h th2=%h expected 100 33333333 44444444", n, out_theta1, out_theta2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (job_count !== 16'd7) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected 7", job_count);
    end
  endtask

  task automatic test_reset_mid_job;
    int spurious;
    in_x = 32'h00010000; in_y = 32'h00010000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (49) tick();
    rst = 1'b1;
    #2;
    tests_run++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b0000 || {ik_x, ik_y, out_theta1, out_theta2, job_count} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_async: got rdy=%b vld=%b busy=%b err=%b ik_x=%h th1=%h jc=%0d expected all 0", in_ready, out_valid, busy, out_err, ik_x, out_theta1, job_count);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_ready: got %b expected 1", in_ready);
    end
    spurious = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    tests_run++;
    if (spurious != 0 || job_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: got spurious=%0d jc=%0d expected 0 0", spurious, job_count);
    end
  endtask

  task automatic test_counter_wrap;
    in_x = 32'h000C0000; in_y = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    repeat (65535) tick();
    tests_run++;
    if (job_count !== 16'hFFFF || out_valid !== 1'b1 || out_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_ffff: got jc=%h vld=%b err=%b expected FFFF 1 1", job_count, out_valid, out_err);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (job_count !== 16'h0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_zero: got jc=%h vld=%b expected 0000 0", job_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_boundary_backpressure();
    test_back_to_back();
    test_reset_mid_job();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
